serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: A  input  WIDTH  minuend, sampled with start.
REQ-006 SHALL have port: B  input  WIDTH  subtrahend, sampled with start.
REQ-007 SHALL have port: Bin  input  1  borrow-in, sampled with start.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: D  output  WIDTH  difference A-B-Bin, modulo 2^WIDTH.
REQ-011 SHALL have port: Bout  output  1  borrow-out, 1 when A < B+Bin unsigned.
REQ-012 SHALL have port: OVF  output  1  signed overflow of the two's-complement difference.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start, SHIFT->DONE after WIDTH bit-cycles, DONE->IDLE unconditionally.
REQ-014 SHALL, on start in IDLE, latch A, B into shift registers and Bin into the borrow flip-flop in the same edge.
REQ-015 SHALL process one bit per cycle, LSB first, through one 1-bit full subtractor: d = a^b^br, br_next = (~a&b) | (~(a^b)&br).
REQ-016 SHALL shift each difference bit into the result register MSB-first-in so that after WIDTH cycles D[0] holds the first bit computed.
REQ-017 SHALL assert done for exactly one cycle, WIDTH+1 edges after the edge sampling start (start at edge 0, done high after edge WIDTH+1).
REQ-018 SHALL update D, Bout, OVF only on the edge entering DONE and hold them stable until the next operation completes.
REQ-019 SHALL compute OVF = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]) using latched operand signs.
REQ-020 SHALL ignore start while in SHIFT or DONE; operands on A/B/Bin may change freely after sampling.
REQ-021 SHALL accept start in the cycle immediately after DONE (back-to-back ops, period WIDTH+2 cycles).
REQ-022 SHALL hold busy high in SHIFT only; busy and done never both high.

Reset
REQ-023 SHALL, when rst_n is low at a rising edge, enter IDLE and clear D, Bout, OVF, busy, done, shift registers, bit counter and borrow flip-flop to 0.
REQ-024 SHALL abort an in-progress operation on reset with no done pulse and no result update.
REQ-025 SHALL have reset take priority over start in the same cycle.

Structure
REQ-026 SHALL place state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH in a shared constants include/package.
REQ-027 SHALL instantiate one sub-module fullsubM (ports A, B, Bin, D, Bout; combinational 1-bit full subtractor) for the bit datapath.
REQ-028 SHALL size the bit counter to $clog2(WIDTH+1) bits.

Verification (WIDTH=8)
REQ-029 SHALL test A=0x05, B=0x03, Bin=0 -> D=0x02, Bout=0, OVF=0, done 9 edges after start.
REQ-030 SHALL test A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1, OVF=0.
REQ-031 SHALL test A=0x80, B=0x01, Bin=0 -> D=0x7F, Bout=0, OVF=1; and A=0x10, B=0x0F, Bin=1 -> D=0x00, Bout=0.
REQ-032 SHALL test start pulsed again at cycle 3 of an op with A=0xFF -> ignored, first result unchanged, exactly one done.
REQ-033 SHALL test rst_n low at cycle 4 of an op -> no done, D=0x00, busy=0; then new op 0x09-0x09 -> D=0x00, Bout=0.
REQ-034 SHALL test back-to-back: start asserted the cycle after done -> second result correct, done spacing 10 cycles.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared constants for the bit-serial subtractor:
//     - DEFAULT_WIDTH : default operand/result width
//     - state_e       : control FSM encoding (IDLE=0, SHIFT=1, DONE=2)
//     - sub_overflow  : two's-complement overflow rule for a difference,
//                       expressed on the operand and result sign bits
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A - B can only overflow when the operands have opposite signs; it has
  // overflowed when the result sign then disagrees with the minuend sign.
  function automatic logic sub_overflow(input logic a_sign,
                                        input logic b_sign,
                                        input logic d_sign);
    return (a_sign != b_sign) && (d_sign != a_sign);
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_fullsubM.sv
// -----------------------------------------------------------------------------
// fullsubM
//   Combinational 1-bit full subtractor computing A - B - Bin.
//   Ports:
//     A    : minuend bit
//     B    : subtrahend bit
//     Bin  : borrow in
//     D    : difference bit   (A ^ B ^ Bin)
//     Bout : borrow out       (~A & B) | (~(A ^ B) & Bin)
// -----------------------------------------------------------------------------
module fullsubM (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic a_xor_b;

  assign a_xor_b = A ^ B;
  assign D       = a_xor_b ^ Bin;
  // A borrow is generated when A=0,B=1, and propagated when A==B.
  assign Bout    = (~A & B) | (~a_xor_b & Bin);

endmodule : fullsubM

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: computes D = A - B - Bin (mod 2^WIDTH) one bit per
//   clock, LSB first, through a single 1-bit full subtractor.
//
//   Parameters:
//     WIDTH : operand/result width in bits (2..32)
//
//   Ports:
//     clk   : clock, all state updates on the rising edge
//     rst_n : synchronous active-low reset
//     start : request, only looked at while idle
//     A     : minuend, captured with start
//     B     : subtrahend, captured with start
//     Bin   : borrow-in, captured with start
//     busy  : high while bits are being processed
//     done  : one-cycle pulse, D/Bout/OVF are valid
//     D     : difference
//     Bout  : borrow-out (A < B + Bin, unsigned)
//     OVF   : two's-complement overflow of the difference
//
//   Timing (start sampled at edge 0):
//     edges 1..WIDTH  : one bit processed per edge, the last one also loads
//                       D/Bout/OVF and moves the FSM into DONE
//     edge  WIDTH+1   : DONE -> IDLE, done pulses for the following cycle
//   Because the FSM is already back in IDLE while done is high, a start
//   presented alongside done is accepted, giving a WIDTH+2 cycle period.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             OVF
);

  // Counter must be able to hold WIDTH itself (value after the last bit).
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // minuend shift register, LSB consumed
  logic [WIDTH-1:0] b_q, b_d;       // subtrahend shift register
  logic [WIDTH-1:0] res_q, res_d;   // difference bits, entering at the MSB
  logic             br_q, br_d;     // borrow flip-flop between bit-cycles
  logic [CW-1:0]    cnt_q, cnt_d;   // bits processed so far
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_diff;
  logic             bit_borrow;
  logic [WIDTH-1:0] res_shifted;

  fullsubM u_fullsub (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (br_q),
    .D    (bit_diff),
    .Bout (bit_borrow)
  );

  // After WIDTH shifts the first bit computed has walked down to bit 0.
  assign res_shifted = {bit_diff, res_q[WIDTH-1:1]};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = bit_borrow;
        res_d = res_shifted;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          // On the last bit a_q[0]/b_q[0] are the captured operand signs.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          d_d     = res_shifted;
          bout_d  = bit_borrow;
          ovf_d   = sub_overflow(a_q[0], b_q[0], bit_diff);
        end else begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign OVF  = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8): directed corner cases
//   followed by randomized operations, all compared against an arithmetic
//   reference model of A - B - Bin.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         OVF;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_done_cyc = 0;
  logic [W-1:0] last_exp_d;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .OVF   (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int diff;
    diff = int'(a) - int'(b) - int'(bin);
    d  = diff[W-1:0];
    bo = (diff < 0);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endtask

  // One full operation: present operands, scramble inputs after sampling,
  // wait (bounded) for done, then compare result and latency.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           edges;
    bit           seen;
    model(a, b, bin, ed, eb, eo);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      check("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (done) seen = 1'b1;
      else check("busy_level", 32'(busy), (edges < W) ? 32'd1 : 32'd0);
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_latency", 32'(edges), 32'(W + 1));
    check("D", 32'(D), 32'(ed));
    check("Bout", 32'(Bout), 32'(eb));
    check("OVF", 32'(OVF), 32'(eo));
    last_done_cyc = cyc;
    last_exp_d    = ed;
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 8'h00;
      1:       v = 8'h80;
      2:       v = 8'h7F;
      3:       v = 8'hFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [W-1:0] ed;
    logic         eb, eo;
    int           n_done, lat, prev_done, gap;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_D", 32'(D), 32'd0);
    check("reset_Bout", 32'(Bout), 32'd0);
    check("reset_OVF", 32'(OVF), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    do_op(8'h05, 8'h03, 1'b0);
    check("c1_D", 32'(D), 32'h02);
    check("c1_Bout", 32'(Bout), 32'd0);
    check("c1_OVF", 32'(OVF), 32'd0);
    do_op(8'h00, 8'h01, 1'b0);
    check("c2_D", 32'(D), 32'hFF);
    check("c2_Bout", 32'(Bout), 32'd1);
    check("c2_OVF", 32'(OVF), 32'd0);
    do_op(8'h80, 8'h01, 1'b0);
    check("c3_D", 32'(D), 32'h7F);
    check("c3_Bout", 32'(Bout), 32'd0);
    check("c3_OVF", 32'(OVF), 32'd1);
    do_op(8'h10, 8'h0F, 1'b1);
    check("c4_D", 32'(D), 32'h00);
    check("c4_Bout", 32'(Bout), 32'd0);

    // A second start three edges into an operation must be ignored.
    repeat (2) @(posedge clk);
    model(8'h3C, 8'h15, 1'b0, ed, eb, eo);
    @(negedge clk);
    A = 8'h3C; B = 8'h15; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    lat    = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin A = 8'hFF; B = 8'h00; Bin = 1'b0; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        n_done++;
        if (lat == 0) lat = k;
      end
    end
    check("ignore_done_count", 32'(n_done), 32'd1);
    check("ignore_latency", 32'(lat), 32'(W + 1));
    check("ignore_D", 32'(D), 32'(ed));
    check("ignore_Bout", 32'(Bout), 32'(eb));

    // Reset four edges into an operation aborts it.
    @(negedge clk);
    A = 8'h55; B = 8'h22; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_D", 32'(D), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_D_held", 32'(D), 32'd0);
    do_op(8'h09, 8'h09, 1'b0);
    check("after_abort_D", 32'(D), 32'h00);
    check("after_abort_Bout", 32'(Bout), 32'd0);

    // Back-to-back: start offered in the cycle right after DONE.
    do_op(8'hA7, 8'h3B, 1'b1);
    prev_done = last_done_cyc;
    do_op(8'h12, 8'hC4, 1'b0);
    check("b2b_spacing", 32'(last_done_cyc - prev_done), 32'(W + 2));

    // Randomized operations with random idle gaps (gap 0 is back-to-back).
    gap = 0;
    for (int n = 0; n < 40; n++) begin
      prev_done = last_done_cyc;
      do_op(pick_operand(), pick_operand(), 1'($urandom));
      if (gap == 0 && n > 0)
        check("rand_b2b_spacing", 32'(last_done_cyc - prev_done), 32'(W + 2));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        check("rand_done_low", 32'(done), 32'd0);
        check("rand_D_stable", 32'(D), 32'(last_exp_d));
      end
    end
    @(posedge clk); #1;
    check("final_done_low", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
